// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: pulses the PLL reset, qualifies lock through a 2-FF
// synchronizer, retries on lock timeout, and releases the downstream reset
// only after lock has been continuously stable for a programmed interval.
module pll_lock_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int CNT_W               = 16,
  parameter int EVT_W               = 8
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             soft_relock,
  input  logic             cnt_clear,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             lock_ok,
  output logic [EVT_W-1:0] relock_cnt,
  output logic [EVT_W-1:0] timeout_cnt,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [EVT_W-1:0] EVT_MAX      = {EVT_W{1'b1}};

  logic             lk_meta;
  logic             lk_s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_nxt;
  logic             relock_inc;
  logic             timeout_inc;

  // Bring the asynchronous PLL lock indication into the refclk domain
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      lk_meta <= pll_locked;
      lk_s    <= lk_meta;
    end
  end

  // Next-state, shared timer and event-strobe decode; soft relock overrides everything
  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    relock_inc  = 1'b0;
    timeout_inc = 1'b0;
    if (soft_relock) begin
      state_nxt = RESET_PLL;
      timer_nxt = '0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (timer == RST_LAST) begin
            state_nxt = WAIT_LOCK;
            timer_nxt = '0;
          end else begin
            timer_nxt = timer + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (lk_s) begin
            state_nxt = STABLE;
            timer_nxt = '0;
          end else if (timer == TIMEOUT_LAST) begin
            state_nxt   = RESET_PLL;
            timer_nxt   = '0;
            timeout_inc = 1'b1;
          end else begin
            timer_nxt = timer + CNT_W'(1);
          end
        end
        STABLE: begin
          if (!lk_s) begin
            state_nxt = WAIT_LOCK;
            timer_nxt = '0;
          end else if (timer == STABLE_LAST) begin
            state_nxt = RUN;
            timer_nxt = '0;
          end else begin
            timer_nxt = timer + CNT_W'(1);
          end
        end
        RUN: begin
          timer_nxt = '0;
          if (!lk_s) begin
            state_nxt  = RESET_PLL;
            relock_inc = 1'b1;
          end
        end
        default: begin
          state_nxt = RESET_PLL;
          timer_nxt = '0;
        end
      endcase
    end
  end

  // State, timer and registered outputs decoded from the upcoming state
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RESET_PLL;
      timer     <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      lock_ok   <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      pll_rst   <= (state_nxt == RESET_PLL);
      sys_rst_n <= (state_nxt == RUN);
      lock_ok   <= (state_nxt == RUN);
    end
  end

  // Saturating event counters with clear taking priority over increment
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      relock_cnt  <= '0;
      timeout_cnt <= '0;
    end else if (cnt_clear) begin
      relock_cnt  <= '0;
      timeout_cnt <= '0;
    end else begin
      if (relock_inc && (relock_cnt != EVT_MAX)) begin
        relock_cnt <= relock_cnt + EVT_W'(1);
      end
      if (timeout_inc && (timeout_cnt != EVT_MAX)) begin
        timeout_cnt <= timeout_cnt + EVT_W'(1);
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with a small expectation scoreboard.
module tb_pll_lock_sequencer;

  localparam int EVT_W = 4;

  localparam int SEL_PLL_RST   = 0;
  localparam int SEL_SYS_RST_N = 1;

  logic             refclk = 1'b0;
  logic             rst_n;
  logic             pll_locked;
  logic             soft_relock;
  logic             cnt_clear;
  logic             pll_rst;
  logic             sys_rst_n;
  logic             lock_ok;
  logic [EVT_W-1:0] relock_cnt;
  logic [EVT_W-1:0] timeout_cnt;
  logic [1:0]       state_o;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t exp_q[$];
  int   check_cnt = 0;
  int   pass_cnt  = 0;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_TIMEOUT_CYCLES(100),
    .LOCK_STABLE_CYCLES (8),
    .CNT_W              (16),
    .EVT_W              (EVT_W)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .soft_relock(soft_relock),
    .cnt_clear  (cnt_clear),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .lock_ok    (lock_ok),
    .relock_cnt (relock_cnt),
    .timeout_cnt(timeout_cnt),
    .state_o    (state_o)
  );

  // Free-running reference clock
  always #5 refclk = ~refclk;

  task automatic step();
    @(negedge refclk);
  endtask

  task automatic push_expect(input string tag, input logic [31:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    exp_q.push_back(e);
  endtask

  task automatic check_output(input logic [31:0] observed);
    exp_t e;
    check_cnt++;
    if (exp_q.size() == 0) begin
      $display("[TB] FAIL scoreboard_empty: observed %0d required an expectation", observed);
    end else begin
      e = exp_q.pop_front();
      assert (observed === e.value) pass_cnt++;
      else $error("[TB] FAIL %s: observed %0d expected %0d", e.tag, observed, e.value);
    end
  endtask

  function automatic logic sig_value(input int sel);
    if (sel == SEL_PLL_RST) return pll_rst;
    return sys_rst_n;
  endfunction

  // Count negedge samples until the selected output reaches val (bounded)
  task automatic cycles_until(input int sel, input logic val, input int limit, output int n);
    n = 0;
    while ((sig_value(sel) !== val) && (n < limit)) begin
      step();
      n++;
    end
    if (sig_value(sel) !== val) begin
      check_cnt++;
      $display("[TB] FAIL wait_timeout: signal %0d still %b after %0d cycles, required %b",
               sel, sig_value(sel), n, val);
    end
  endtask

  task automatic expect_reset_values(input string prefix);
    push_expect({prefix, "_pll_rst"}, 1);
    push_expect({prefix, "_sys_rst_n"}, 0);
    push_expect({prefix, "_lock_ok"}, 0);
    push_expect({prefix, "_state"}, 0);
    push_expect({prefix, "_relock_cnt"}, 0);
    push_expect({prefix, "_timeout_cnt"}, 0);
    check_output(32'(pll_rst));
    check_output(32'(sys_rst_n));
    check_output(32'(lock_ok));
    check_output(32'(state_o));
    check_output(32'(relock_cnt));
    check_output(32'(timeout_cnt));
  endtask

  initial begin
    int n;
    rst_n       = 1'b0;
    pll_locked  = 1'b0;
    soft_relock = 1'b0;
    cnt_clear   = 1'b0;
    repeat (3) step();

    // Reset state and first PLL reset pulse
    expect_reset_values("reset");
    push_expect("first_pulse_len", 4);
    rst_n = 1'b1;
    cycles_until(SEL_PLL_RST, 1'b0, 50, n);
    check_output(n);
    push_expect("first_wait_state", 1);
    check_output(32'(state_o));

    // Lock arrives 20 cycles into WAIT_LOCK: 2 sync + 1 detect + 8 stable
    repeat (19) step();
    push_expect("first_release_lat", 11);
    pll_locked = 1'b1;
    cycles_until(SEL_SYS_RST_N, 1'b1, 200, n);
    check_output(n);
    push_expect("run_state", 3);
    push_expect("run_lock_ok", 1);
    push_expect("run_relock_cnt", 0);
    push_expect("run_timeout_cnt", 0);
    check_output(32'(state_o));
    check_output(32'(lock_ok));
    check_output(32'(relock_cnt));
    check_output(32'(timeout_cnt));

    // Loss of lock in RUN
    push_expect("drop_lat", 3);
    pll_locked = 1'b0;
    cycles_until(SEL_SYS_RST_N, 1'b0, 50, n);
    check_output(n);
    push_expect("drop_pll_rst", 1);
    check_output(32'(pll_rst));
    push_expect("drop_pulse_len", 4);
    cycles_until(SEL_PLL_RST, 1'b0, 50, n);
    check_output(n);
    push_expect("drop_relock_cnt", 1);
    check_output(32'(relock_cnt));
    push_expect("relock_release_lat", 11);
    pll_locked = 1'b1;
    cycles_until(SEL_SYS_RST_N, 1'b1, 200, n);
    check_output(n);
    push_expect("relock_state", 3);
    check_output(32'(state_o));

    // One-cycle soft relock from RUN
    push_expect("soft_sys_rst_n", 0);
    push_expect("soft_pll_rst", 1);
    push_expect("soft_state", 0);
    push_expect("soft_relock_cnt", 1);
    soft_relock = 1'b1;
    step();
    soft_relock = 1'b0;
    check_output(32'(sys_rst_n));
    check_output(32'(pll_rst));
    check_output(32'(state_o));
    check_output(32'(relock_cnt));
    push_expect("soft_pulse_len", 4);
    cycles_until(SEL_PLL_RST, 1'b0, 50, n);
    check_output(n);

    // Lock glitch reaching the state machine at stable count 5
    step();
    push_expect("glitch_stable_entry", 2);
    check_output(32'(state_o));
    repeat (3) step();
    pll_locked = 1'b0;
    repeat (3) step();
    push_expect("glitch_back_to_wait", 1);
    push_expect("glitch_sys_rst_n", 0);
    check_output(32'(state_o));
    check_output(32'(sys_rst_n));
    push_expect("glitch_release_lat", 11);
    pll_locked = 1'b1;
    cycles_until(SEL_SYS_RST_N, 1'b1, 200, n);
    check_output(n);
    push_expect("glitch_relock_cnt", 1);
    push_expect("glitch_timeout_cnt", 0);
    check_output(32'(relock_cnt));
    check_output(32'(timeout_cnt));

    // Asynchronous reset in the middle of STABLE
    soft_relock = 1'b1;
    step();
    soft_relock = 1'b0;
    push_expect("pre_async_pulse_len", 4);
    cycles_until(SEL_PLL_RST, 1'b0, 50, n);
    check_output(n);
    step();
    push_expect("pre_async_stable", 2);
    check_output(32'(state_o));
    repeat (2) step();
    pll_locked = 1'b0;
    #2 rst_n = 1'b0;
    #1 expect_reset_values("async");
    step();
    push_expect("restart_pulse_len", 4);
    rst_n = 1'b1;
    cycles_until(SEL_PLL_RST, 1'b0, 50, n);
    check_output(n);
    push_expect("restart_wait_state", 1);
    check_output(32'(state_o));

    // Repeated lock timeouts with saturating event counter
    for (int k = 1; k <= 17; k++) begin
      push_expect("timeout_wait_len", 100);
      cycles_until(SEL_PLL_RST, 1'b1, 300, n);
      check_output(n);
      push_expect("timeout_cnt", (k > 15) ? 15 : k);
      check_output(32'(timeout_cnt));
      push_expect("timeout_pulse_len", 4);
      cycles_until(SEL_PLL_RST, 1'b0, 50, n);
      check_output(n);
    end
    push_expect("timeout_relock_cnt", 0);
    check_output(32'(relock_cnt));

    // Synchronous counter clear
    push_expect("clear_timeout_cnt", 0);
    push_expect("clear_relock_cnt", 0);
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    check_output(32'(timeout_cnt));
    check_output(32'(relock_cnt));

    if (exp_q.size() != 0) begin
      check_cnt++;
      $display("[TB] FAIL scoreboard_leftover: %0d expectations unconsumed, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
